// File: rtl/dk_pkg.sv
// dk_pkg: shared motion codes, keycodes and controller state type
package dk_pkg;
  localparam logic [3:0] IDLE_R = 4'd1;
  localparam logic [3:0] IDLE_L = 4'd2;
  localparam logic [3:0] WALK_R = 4'd3;
  localparam logic [3:0] JUMP_R = 4'd4;
  localparam logic [3:0] JUMP_L = 4'd5;
  localparam logic [3:0] WALK_L = 4'd6;
  localparam logic [3:0] FALL_R = 4'd7;
  localparam logic [3:0] FALL_L = 4'd8;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_JUMP  = 8'h29;
  typedef enum logic [1:0] {GROUND, JUMP, FALL} dk_state_t;
endpackage

// File: rtl/dk_motion_ctrl_if.sv
// dk_motion_ctrl_if: mapper/keyboard side signals of the motion controller
interface dk_motion_ctrl_if;
  logic [24:0] counter;
  logic [7:0]  keycode;
  logic        press;
  logic [15:0] nextX;
  logic [15:0] nextY;
  logic        grounded;
  logic [15:0] posX;
  logic [15:0] posY;
  logic [3:0]  DKmotion;
  logic [18:0] num;
  logic        facing;
  logic [1:0]  anim_frame;
  modport master (
    output counter, keycode, press, nextX, nextY, grounded,
    input  posX, posY, DKmotion, num, facing, anim_frame
  );
  modport slave (
    input  counter, keycode, press, nextX, nextY, grounded,
    output posX, posY, DKmotion, num, facing, anim_frame
  );
endinterface

// File: rtl/dk_anim_counter.sv
// dk_anim_counter: tick prescaler driving a 2-bit walk-cycle frame counter
module dk_anim_counter #(
  parameter int FRAME_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  output logic [1:0] frame
);
  localparam int PW = FRAME_TICKS > 1 ? $clog2(FRAME_TICKS) : 1;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    frame_q, frame_d;
  logic          wrap;
  assign wrap  = pre_q == PW'(FRAME_TICKS - 1);
  assign frame = frame_q;
  // advance the prescaler while walking, stepping the frame on wrap; clear otherwise
  always_comb begin
    pre_d   = !enable ? '0 : wrap ? '0 : pre_q + PW'(1);
    frame_d = !enable ? '0 : wrap ? frame_q + 2'd1 : frame_q;
  end
  // prescaler and frame only move on physics ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      frame_q <= '0;
    end else if (tick) begin
      pre_q   <= pre_d;
      frame_q <= frame_d;
    end
  end
endmodule

// File: rtl/dk_motion_ctrl.sv
// dk_motion_ctrl: registers DK position and runs the ground/jump/fall state machine
module dk_motion_ctrl
  import dk_pkg::*;
#(
  parameter int TICK_COUNT      = 4500000,
  parameter int JUMP_RISE_TICKS = 10,
  parameter int FRAME_TICKS     = 4
) (
  input logic             clk,
  input logic             reset,
  dk_motion_ctrl_if.slave bus
);
  dk_state_t   state_q, state_d;
  logic [18:0] num_q, num_d;
  logic [15:0] pos_x_q, pos_y_q;
  logic        facing_q, facing_d;
  logic        armed_q, armed_d;
  logic        tick, jump_key, walking, launch;
  logic [1:0]  frame;
  assign tick     = bus.counter == 25'(TICK_COUNT);
  assign jump_key = bus.press && bus.keycode == KEY_JUMP;
  assign walking  = bus.press && (bus.keycode == KEY_RIGHT || bus.keycode == KEY_LEFT);
  assign launch   = tick && state_q == GROUND && jump_key && armed_q;
  assign bus.posX       = pos_x_q;
  assign bus.posY       = pos_y_q;
  assign bus.num        = num_q;
  assign bus.facing     = facing_q;
  assign bus.anim_frame = frame;
  assign bus.DKmotion   = state_q == JUMP ? (facing_q ? JUMP_L : JUMP_R) :
                          state_q == FALL ? (facing_q ? FALL_L : FALL_R) :
                          walking         ? (facing_q ? WALK_L : WALK_R) :
                                            (facing_q ? IDLE_L : IDLE_R);
  // next state: arming is evaluated every clock, everything else only on ticks
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    facing_d = facing_q;
    armed_d  = launch ? 1'b0 : !jump_key ? 1'b1 : armed_q;
    if (tick) begin
      facing_d = (bus.press && bus.keycode == KEY_RIGHT) ? 1'b0 :
                 (bus.press && bus.keycode == KEY_LEFT)  ? 1'b1 : facing_q;
      case (state_q)
        GROUND: begin
          if (launch) begin
            state_d = JUMP;
            num_d   = '0;
          end else if (!bus.grounded) begin
            state_d = FALL;
          end
        end
        JUMP: begin
          num_d   = num_q + 19'd1;
          state_d = num_q == 19'(JUMP_RISE_TICKS - 1) ? FALL : JUMP;
        end
        default: begin
          state_d = bus.grounded ? GROUND : FALL;
          num_d   = bus.grounded ? '0 : &num_q ? num_q : num_q + 19'd1;
        end
      endcase
    end
  end
  // state, jump count, facing and arming registers; position samples the mapper on ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FALL;
      num_q    <= '0;
      facing_q <= 1'b0;
      armed_q  <= 1'b1;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      facing_q <= facing_d;
      armed_q  <= armed_d;
      if (tick) begin
        pos_x_q <= bus.nextX;
        pos_y_q <= bus.nextY;
      end
    end
  end
  dk_anim_counter #(.FRAME_TICKS(FRAME_TICKS)) u_anim (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .enable (state_q == GROUND && walking),
    .frame  (frame)
  );
endmodule

// File: tb/tb_dk_motion_ctrl.sv
// tb_dk_motion_ctrl: directed scoreboard bench for the DK motion controller
module tb_dk_motion_ctrl;
  import dk_pkg::*;
  localparam int TC = 4500000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dk_motion_ctrl_if bus();
  dk_motion_ctrl #(.TICK_COUNT(TC), .JUMP_RISE_TICKS(10), .FRAME_TICKS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  typedef struct {
    string       tag;
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  m;
    logic [18:0] n;
    logic        f;
    logic [1:0]  a;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic compare_out();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (bus.posX === e.x) else begin failures++; $error("FAIL %s posX got=%0d exp=%0d", e.tag, bus.posX, e.x); end
    checks++;
    assert (bus.posY === e.y) else begin failures++; $error("FAIL %s posY got=%0d exp=%0d", e.tag, bus.posY, e.y); end
    checks++;
    assert (bus.DKmotion === e.m) else begin failures++; $error("FAIL %s DKmotion got=%0d exp=%0d", e.tag, bus.DKmotion, e.m); end
    checks++;
    assert (bus.num === e.n) else begin failures++; $error("FAIL %s num got=%0d exp=%0d", e.tag, bus.num, e.n); end
    checks++;
    assert (bus.facing === e.f) else begin failures++; $error("FAIL %s facing got=%0d exp=%0d", e.tag, bus.facing, e.f); end
    checks++;
    assert (bus.anim_frame === e.a) else begin failures++; $error("FAIL %s anim_frame got=%0d exp=%0d", e.tag, bus.anim_frame, e.a); end
  endtask

  task automatic step(input string tag, input logic rs, input logic tk, input logic p,
                      input logic [7:0] k, input logic [15:0] nx, input logic [15:0] ny,
                      input logic g, input logic [15:0] ex, input logic [15:0] ey,
                      input logic [3:0] m, input logic [18:0] n, input logic f,
                      input logic [1:0] a);
    exp_t e;
    reset        = rs;
    bus.counter  = tk ? 25'(TC) : 25'($urandom_range(0, TC - 1));
    bus.press    = p;
    bus.keycode  = k;
    bus.nextX    = nx;
    bus.nextY    = ny;
    bus.grounded = g;
    e.tag = tag; e.x = ex; e.y = ey; e.m = m; e.n = n; e.f = f; e.a = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    bus.counter = 25'd0;
    compare_out();
  endtask

  initial begin
    bus.counter = 25'd0; bus.press = 1'b0; bus.keycode = 8'h00;
    bus.nextX = 16'd0; bus.nextY = 16'd0; bus.grounded = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 1, 0, 0, 8'h00, 16'd5, 16'd5, 0, 16'd0, 16'd0, 4'd7, 19'd0, 0, 2'd0);
    for (int i = 1; i <= 5; i++)
      step("fall", 0, 1, 0, 8'h00, 16'd100, 16'(8 * i), 0, 16'd100, 16'(8 * i), 4'd7, 19'(i), 0, 2'd0);
    step("land", 0, 1, 0, 8'h00, 16'd100, 16'd48, 1, 16'd100, 16'd48, 4'd1, 19'd0, 0, 2'd0);
    for (int t = 1; t <= 30; t++)
      step("hold_jump", 0, 1, 1, KEY_JUMP, 16'd100, 16'd48, 1, 16'd100, 16'd48,
           t <= 10 ? 4'd4 : t == 11 ? 4'd7 : 4'd1,
           t <= 10 ? 19'(t - 1) : t == 11 ? 19'd10 : 19'd0, 0, 2'd0);
    step("rearm_idle", 0, 0, 0, KEY_JUMP, 16'd100, 16'd48, 1, 16'd100, 16'd48, 4'd1, 19'd0, 0, 2'd0);
    for (int t = 1; t <= 12; t++)
      step("rejump", 0, 1, t == 1, KEY_JUMP, 16'd100, 16'd48, 1, 16'd100, 16'd48,
           t <= 10 ? 4'd4 : t == 11 ? 4'd7 : 4'd1,
           t <= 10 ? 19'(t - 1) : t == 11 ? 19'd10 : 19'd0, 0, 2'd0);
    for (int t = 1; t <= 8; t++)
      step("walk_left", 0, 1, 1, KEY_LEFT, 16'(100 - t), 16'd48, 1, 16'(100 - t), 16'd48,
           4'd6, 19'd0, 1, t < 4 ? 2'd0 : t < 8 ? 2'd1 : 2'd2);
    step("release", 0, 1, 0, KEY_LEFT, 16'd92, 16'd48, 1, 16'd92, 16'd48, 4'd2, 19'd0, 1, 2'd0);
    step("jump_left", 0, 1, 1, KEY_JUMP, 16'd92, 16'd48, 1, 16'd92, 16'd48, 4'd5, 19'd0, 1, 2'd0);
    for (int t = 1; t <= 5; t++)
      step("rise_left", 0, 1, 0, 8'h00, 16'd92, 16'(48 - 8 * t), 1, 16'd92, 16'(48 - 8 * t), 4'd5, 19'(t), 1, 2'd0);
    step("reset_tick", 1, 1, 1, KEY_LEFT, 16'd200, 16'd300, 1, 16'd0, 16'd0, 4'd7, 19'd0, 0, 2'd0);
    step("land2", 0, 1, 0, 8'h00, 16'd50, 16'd60, 1, 16'd50, 16'd60, 4'd1, 19'd0, 0, 2'd0);
    step("walk_off", 0, 1, 0, 8'h00, 16'd50, 16'd60, 0, 16'd50, 16'd60, 4'd7, 19'd0, 0, 2'd0);
    for (int c = 0; c < 100; c++)
      step("stable", 0, 0, 0, 8'h00, 16'($urandom), 16'($urandom), 1'($urandom), 16'd50, 16'd60, 4'd7, 19'd0, 0, 2'd0);
    step("land3", 0, 1, 0, 8'h00, 16'd50, 16'd60, 1, 16'd50, 16'd60, 4'd1, 19'd0, 0, 2'd0);
    step("jump_over_walkoff", 0, 1, 1, KEY_JUMP, 16'd50, 16'd52, 0, 16'd50, 16'd52, 4'd4, 19'd0, 0, 2'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dk_motion_ctrl.md
# dk_motion_ctrl

Sequential motion controller for Donkey Kong, directly downstream of the combinational position/ground mapper. Registers the mapper's next position into the `prevX`/`prevY` feedback, runs the ground/jump/fall state machine, and produces the `DKmotion` sprite code and `num` jump-tick count that the mapper and sprite renderer consume. It also owns the walk-animation frame counter.

## Interface
Parameters:
- `TICK_COUNT`, default 4500000: value of `counter` that marks a physics tick. Must match the mapper.
- `JUMP_RISE_TICKS`, default 10: number of rising ticks per jump.
- `FRAME_TICKS`, default 4: physics ticks per walk-animation frame.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `counter`, input, 25: free-running tick counter shared with the mapper.
- `keycode`, input, 8: last PS/2 keycode. 0x74 = right, 0x6B = left, 0x29 = jump.
- `press`, input, 1: key in `keycode` is currently held.
- `nextX`, input, 16: mapper X output.
- `nextY`, input, 16: mapper Y output.
- `grounded`, input, 1: mapper `no == 1`, meaning the current `posY` is on a ground line.
- `posX`, output, 16: registered X; drives the mapper `prevX`.
- `posY`, output, 16: registered Y; drives the mapper `prevY`.
- `DKmotion`, output, 4: sprite/motion code.
- `num`, output, 19: ticks elapsed in the current jump.
- `facing`, output, 1: 0 = right, 1 = left.
- `anim_frame`, output, 2: walk-cycle frame.

## Operation
Physics tick:
- `tick = (counter == TICK_COUNT)`.
- All state, position, `num`, `facing` and frame updates occur only on tick cycles. Jump arming is the one exception and is sampled every clock.

Position:
- On tick, `posX <= nextX` and `posY <= nextY`. Otherwise both hold.
- `posX`/`posY` are registers only, so there is no combinational path from `nextX`/`nextY` to `posX`/`posY`.

Facing:
- On tick with `press` and `keycode == 0x74`: `facing <= 0`.
- On tick with `press` and `keycode == 0x6B`: `facing <= 1`.
- Facing updates in every state, including mid-air.

Jump arming:
- `armed` clears when a jump launches.
- `armed` sets on any clock where `!(press && keycode == 0x29)`.
- Holding the jump key therefore gives exactly one jump.

States and transitions:
- GROUND:
  - On tick with `press && keycode == 0x29 && armed`: go to JUMP, set `num <= 0`, clear `armed`.
  - Otherwise, on tick with `!grounded`: go to FALL (walked off a ledge).
  - Jump takes priority over walk-off when both apply on the same tick.
- JUMP:
  - Each tick: `num <= num + 1`.
  - On the tick where `num == JUMP_RISE_TICKS-1`: go to FALL.
  - `grounded` is ignored in JUMP.
- FALL:
  - On tick with `grounded`: go to GROUND.
  - `num` keeps counting, saturating at 2^19-1.
  - On landing, `num <= 0`.

`DKmotion` decode (combinational from state, facing and walking):
- GROUND, not walking: 1 (IdleR) or 2 (IdleL).
- GROUND, walking: 3 (WalkR) or 6 (WalkL). Walking means `press` with keycode 0x74 or 0x6B.
- JUMP: 4 (JumpR) or 5 (JumpL).
- FALL: 7 (FallR) or 8 (FallL).
- Code 0 is never driven after reset.

Mapper contract:
- The mapper rises 8 px per tick while `DKmotion` is 4 or 5 and `num <= 9`.
- Result: 10 rising ticks, 80 px total per jump.

Animation:
- In GROUND while walking, `anim_frame` advances every `FRAME_TICKS` ticks: 0→1→2→3→0.
- In all other cases, `anim_frame` and its prescaler reset to 0 on the next tick.

## Timing
Reset values:
- `posX = 0`, `posY = 0`.
- State = FALL, so DK drops to the ground after reset.
- `DKmotion = 7`, `num = 0`, `facing = 0`, `anim_frame = 0`, `armed = 1`.

Latency:
- One clock from the tick edge to the updated `posX`/`posY`/`num`/state.
- The mapper sees the new `DKmotion`/`num` on the following tick. The launch tick itself does not rise; the first rise happens one tick later.

Boundary conditions:
- Reset asserted mid-jump or on a tick cycle: reset wins and all registers return to their reset values on that edge.
- `grounded` arriving on the same tick as `num` reaching `JUMP_RISE_TICKS-1`: go to FALL. Landing is evaluated on the next tick.
- Non-tick cycles: all outputs stable.

## Structure
- Package `dk_pkg` holds:
  - the motion-code localparams (IdleR=1 … FallL=8);
  - keycode constants `KEY_RIGHT`, `KEY_LEFT`, `KEY_JUMP`;
  - the state enum `dk_state_t` {GROUND, JUMP, FALL}.
- Sub-module `dk_anim_counter` provides the tick prescaler plus the 2-bit frame counter. Its inputs are `clk`, `reset`, `tick`, `enable`; its output is `frame`.

## Test plan
- Reset, then 5 ticks with `grounded=0` and `nextY` = 8, 16, …: `posY` follows `nextY`, `DKmotion=7`. Assert `grounded` on the next tick: `DKmotion=1`, `num=0`.
- Grounded, hold 0x29 for 30 ticks: exactly one jump. `DKmotion=4` with `num` stepping 0..9, then `DKmotion=7`. No second jump until `press` is dropped and re-pressed after landing.
- Grounded, hold 0x6B for 8 ticks with `FRAME_TICKS=4`: `DKmotion=6`, `facing=1`, `anim_frame` goes 0→1→2. On release, `DKmotion=2` and `anim_frame=0`.
- Mid-jump at `num=5`, assert `reset` on a tick cycle: next cycle `posX=0`, `posY=0`, `DKmotion=7`, `num=0`.
- Grounded, drop `grounded` to 0 with no keys held: next tick `DKmotion=7` (walk-off). With `counter != TICK_COUNT`, all outputs stay unchanged for 100 cycles.
